// File: rtl/period_meter.sv
// Oscillator period meter: counts clk cycles across 2^DIV_BITS rising edges of freq_i.
// Optional input glitch filter is enabled by defining PERIOD_METER_DEGLITCH_EN.
module period_meter #(
  parameter int unsigned DATA_BITS       = 28,
  parameter int unsigned DIV_BITS        = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1048576,
  parameter int unsigned DEGLITCH_CYCLES = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable_i,
  input  logic                 freq_i,
  output logic [DATA_BITS-1:0] out_value_o,
  output logic                 out_valid_o,
  output logic                 stalled_o
);

  typedef enum logic {IDLE = 1'b0, MEASURE = 1'b1} state_e;

  localparam int unsigned ECNT_W = DIV_BITS + 1;
  localparam logic [ECNT_W-1:0]    ECNT_LAST = ECNT_W'((1 << DIV_BITS) - 1);
  localparam logic [DATA_BITS-1:0] CNT_LAST  = DATA_BITS'(TIMEOUT_CYCLES - 1);

  if (DIV_BITS > 8) begin : g_bad_div
    $error("period_meter: DIV_BITS must be in 0..8");
  end
  if (TIMEOUT_CYCLES < 1 || longint'(TIMEOUT_CYCLES) > (longint'(1) << DATA_BITS) - 1) begin : g_bad_timeout
    $error("period_meter: TIMEOUT_CYCLES out of range");
  end
  if (DEGLITCH_CYCLES < 1) begin : g_bad_deglitch
    $error("period_meter: DEGLITCH_CYCLES must be at least 1");
  end

  state_e                 state_q, state_d;
  logic                   sync1_q, sync2_q, edge_q;
  logic                   lvl;
  logic                   rise;
  logic [DATA_BITS-1:0]   cnt_q, cnt_d;
  logic [ECNT_W-1:0]      ecnt_q, ecnt_d;
  logic [DATA_BITS-1:0]   value_q, value_d;
  logic                   valid_q, valid_d;
  logic                   stalled_q, stalled_d;
  logic                   win_done;
  logic                   timeout_hit;

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= freq_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef PERIOD_METER_DEGLITCH_EN
  localparam int unsigned STAB_W = $clog2(DEGLITCH_CYCLES + 1);

  logic              filt_q;
  logic [STAB_W-1:0] stab_q;

  // A new level is adopted only after DEGLITCH_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      stab_q <= '0;
    end else if (sync2_q == filt_q) begin
      stab_q <= '0;
    end else if (stab_q == STAB_W'(DEGLITCH_CYCLES - 1)) begin
      filt_q <= sync2_q;
      stab_q <= '0;
    end else begin
      stab_q <= stab_q + STAB_W'(1);
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_q <= 1'b0;
    else        edge_q <= lvl;
  end

  assign rise        = lvl & ~edge_q;
  assign win_done    = rise && (ecnt_q == ECNT_LAST);
  assign timeout_hit = (cnt_q == CNT_LAST) && !win_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (rise)        state_d = MEASURE;
        MEASURE: if (timeout_hit) state_d = IDLE;
        default:                  state_d = IDLE;
      endcase
    end
  end

  // NOTE: every variable gets a default first so no path through this block infers a latch.
  always_comb begin
    cnt_d     = cnt_q;
    ecnt_d    = ecnt_q;
    value_d   = value_q;
    valid_d   = 1'b0;
    stalled_d = stalled_q;
    if (enable_i) begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            cnt_d  = '0;
            ecnt_d = '0;
          end
        end
        MEASURE: begin
          cnt_d = cnt_q + DATA_BITS'(1);
          if (rise) ecnt_d = ecnt_q + ECNT_W'(1);
          // The completing edge also opens the next window, so windows abut.
          if (win_done) begin
            value_d   = cnt_q + DATA_BITS'(1);
            valid_d   = 1'b1;
            stalled_d = 1'b0;
            cnt_d     = '0;
            ecnt_d    = '0;
          end else if (timeout_hit) begin
            value_d   = '1;
            valid_d   = 1'b1;
            stalled_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      ecnt_q    <= '0;
      value_q   <= '0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ecnt_q    <= ecnt_d;
      value_q   <= value_d;
      valid_q   <= valid_d;
      stalled_q <= stalled_d;
    end
  end

  assign out_value_o = value_q;
  assign out_valid_o = valid_q;
  assign stalled_o   = stalled_q;

endmodule
